dm_access_ctrl: RTL and testbench

//  Initiator side of the data-memory interface: accepts load/store requests from the MEM stage,

---
 rtl/dm_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Data-memory access initiator: alignment check, lane steering, req/ack handshake, load extension.
// Optional REQ-phase watchdog enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_we;
  logic [2:0]        r_type;
  logic [1:0]        r_addr_lo;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_rsp_rdata;

  logic              w_accept;
  logic              w_legal;
  logic              w_misalign;
  logic              w_ok;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic              w_timeout;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    w_be       = '0;
    w_wdata    = '0;
    case (req_type)
      3'b000: begin
        w_legal    = 1'b1;
        w_misalign = (req_addr[1:0] != 2'b00);
        w_be       = 4'b1111;
        w_wdata    = req_wdata;
      end
      3'b100, 3'b101: begin
        w_legal    = 1'b1;
        w_misalign = req_addr[0];
        w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{req_wdata[15:0]}};
      end
      3'b110, 3'b111: begin
        w_legal    = 1'b1;
        w_be       = 4'b0001 << req_addr[1:0];
        w_wdata    = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign w_ok = w_legal && !w_misalign;

  // Extraction uses the latched type/offset, since req_* may change while REQ waits.
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_type)
      3'b000:  w_ext = mem_rdata;
      3'b100:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0000, w_half};
      3'b110:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b111:  w_ext = {24'h000000, w_byte};
      default: w_ext = '0;
    endcase
    if (r_we) w_ext = '0;
  end

`ifdef DM_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // An ack arriving on the limit cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TMO_LAST;
  assign w_timeout    = 1'b0;
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) r_state <= w_ok ? S_REQ : S_ERR;
        S_REQ: begin
          if (mem_ack)        r_state <= S_RESP;
          else if (w_timeout) r_state <= S_ERR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we        <= 1'b0;
      r_type      <= '0;
      r_addr_lo   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      if (w_ok) begin
        r_we        <= req_we;
        r_type      <= req_type;
        r_addr_lo   <= req_addr[1:0];
        r_mem_req   <= 1'b1;
        r_mem_we    <= req_we;
        r_mem_addr  <= req_addr[ADDR_W+1:2];
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end else begin
        r_rsp_rdata <= '0;
      end
    end else if (r_state == S_REQ) begin
      if (mem_ack) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_rsp_rdata <= w_ext;
      end else if (w_timeout) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP) || (r_state == S_ERR);
  assign rsp_err   = (r_state == S_ERR);
  assign rsp_rdata = r_rsp_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl; timeout steps compile only with DM_TIMEOUT_EN.
module tb_dm_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  dm_access_ctrl #(.ADDR_W(5), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge and leaves the bench in cycle 1 after acceptance.
  task automatic issue(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = ty;
    req_addr  = addr;
    req_wdata = wd;
    chk("req_ready_on_issue", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = '0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_be",    32'(mem_be),    32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel_req_ready", 32'(req_ready), 32'd1);

    // sw 0x08, ack in cycle 4
    issue(1'b1, 3'b000, 32'h08, 32'hDEADBEEF);
    chk("sw_mem_req",   32'(mem_req),   32'd1);
    chk("sw_mem_we",    32'(mem_we),    32'd1);
    chk("sw_mem_addr",  32'(mem_addr),  32'd2);
    chk("sw_mem_be",    32'(mem_be),    32'hF);
    chk("sw_mem_wdata", mem_wdata,      32'hDEADBEEF);
    chk("sw_busy1",     32'(busy),      32'd1);
    chk("sw_ready1",    32'(req_ready), 32'd0);
    tick(); tick(); tick();
    chk("sw_mem_req_c4", 32'(mem_req),  32'd1);
    chk("sw_busy_c4",    32'(busy),     32'd1);
    chk("sw_rsp_c4",     32'(rsp_valid), 32'd0);
    ack_now(32'h0);
    chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw_rsp_err",   32'(rsp_err),   32'd0);
    chk("sw_rsp_rdata", rsp_rdata,      32'd0);
    chk("sw_mem_req_drop", 32'(mem_req), 32'd0);
    chk("sw_busy_resp", 32'(busy),      32'd1);
    tick();
    chk("sw_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("sw_idle",      32'(busy),      32'd0);

    // lb / lbu 0x0B
    issue(1'b0, 3'b110, 32'h0B, 32'h0);
    chk("lb_mem_we",   32'(mem_we),   32'd0);
    chk("lb_mem_addr", 32'(mem_addr), 32'd2);
    chk("lb_mem_be",   32'(mem_be),   32'b1000);
    ack_now(32'h80123456);
    chk("lb_valid", 32'(rsp_valid), 32'd1);
    chk("lb_rdata", rsp_rdata, 32'hFFFFFF80);
    tick();
    issue(1'b0, 3'b111, 32'h0B, 32'h0);
    ack_now(32'h80123456);
    chk("lbu_rdata", rsp_rdata, 32'h00000080);
    tick();

    // lh / lhu 0x0A
    issue(1'b0, 3'b100, 32'h0A, 32'h0);
    chk("lh_mem_be", 32'(mem_be), 32'b1100);
    ack_now(32'h80123456);
    chk("lh_rdata", rsp_rdata, 32'hFFFF8012);
    chk("lh_err",   32'(rsp_err), 32'd0);
    tick();
    issue(1'b0, 3'b101, 32'h0A, 32'h0);
    ack_now(32'h80123456);
    chk("lhu_rdata", rsp_rdata, 32'h00008012);
    tick();

    // sh 0x06, sb 0x05
    issue(1'b1, 3'b100, 32'h06, 32'h0000ABCD);
    chk("sh_mem_be",    32'(mem_be),   32'b1100);
    chk("sh_mem_wdata", mem_wdata,     32'hABCDABCD);
    chk("sh_mem_addr",  32'(mem_addr), 32'd1);
    ack_now(32'hFFFFFFFF);
    chk("sh_rdata", rsp_rdata, 32'd0);
    tick();
    issue(1'b1, 3'b110, 32'h05, 32'h00000077);
    chk("sb_mem_be",    32'(mem_be), 32'b0010);
    chk("sb_mem_wdata", mem_wdata,   32'h77777777);
    ack_now(32'h0);
    tick();

    // lw 0x10 with req_valid held during REQ: second request must not be taken
    issue(1'b0, 3'b000, 32'h10, 32'h0);
    req_valid = 1'b1; req_addr = 32'h14;
    tick();
    chk("busy_no_accept", 32'(req_ready), 32'd0);
    chk("busy_addr_hold", 32'(mem_addr),  32'd4);
    req_valid = 1'b0;
    ack_now(32'h12345678);
    chk("lw_rdata", rsp_rdata, 32'h12345678);
    tick();
    chk("lw_back_idle", 32'(busy), 32'd0);

    // error paths, back-to-back
    issue(1'b0, 3'b000, 32'h02, 32'h0);
    chk("e_lw_mem_req", 32'(mem_req),   32'd0);
    chk("e_lw_valid",   32'(rsp_valid), 32'd1);
    chk("e_lw_err",     32'(rsp_err),   32'd1);
    chk("e_lw_rdata",   rsp_rdata,      32'd0);
    tick();
    issue(1'b0, 3'b100, 32'h03, 32'h0);
    chk("e_lh_mem_req", 32'(mem_req), 32'd0);
    chk("e_lh_err",     32'(rsp_err), 32'd1);
    tick();
    issue(1'b0, 3'b010, 32'h00, 32'h0);
    chk("e_ty_mem_req", 32'(mem_req),   32'd0);
    chk("e_ty_valid",   32'(rsp_valid), 32'd1);
    chk("e_ty_err",     32'(rsp_err),   32'd1);
    tick();
    chk("e_ty_pulse", 32'(rsp_valid), 32'd0);

    // stray ack in IDLE
    ack_now(32'h55555555);
    chk("idle_ack_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ack_busy",  32'(busy),      32'd0);

    // reset mid-access
    issue(1'b1, 3'b000, 32'h0C, 32'h11111111);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req),  32'd0);
    chk("arst_busy",    32'(busy),     32'd0);
    chk("arst_addr",    32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ack_now(32'hAAAAAAAA);
    chk("late_ack_valid", 32'(rsp_valid), 32'd0);
    issue(1'b0, 3'b000, 32'h1C, 32'h0);
    chk("post_rst_addr", 32'(mem_addr), 32'd7);
    ack_now(32'hCAFEF00D);
    chk("post_rst_rdata", rsp_rdata, 32'hCAFEF00D);
    tick();

`ifdef DM_TIMEOUT_EN
    issue(1'b0, 3'b000, 32'h00, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_req_c15", 32'(mem_req), 32'd1);
    tick();
    chk("tmo_req_drop", 32'(mem_req),   32'd0);
    chk("tmo_valid",    32'(rsp_valid), 32'd1);
    chk("tmo_err",      32'(rsp_err),   32'd1);
    chk("tmo_rdata",    rsp_rdata,      32'd0);
    tick();
    issue(1'b0, 3'b000, 32'h04, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    ack_now(32'h0BADF00D);
    chk("tmo_ack_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_ack_err",   32'(rsp_err),   32'd0);
    chk("tmo_ack_rdata", rsp_rdata,      32'h0BADF00D);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
